// File: rtl/sm_mac_accum_pkg.sv
// Shared types and helpers for the sign-magnitude MAC accumulator.
// Holds the state encoding, the product width and the saturating adder.
package sm_mac_accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam int PROD_W = 4;
  localparam int SAT_W  = 32;

  typedef struct packed {
    logic signed [SAT_W-1:0] sum;
    logic                    ovf;
  } sat_res_t;

  // Operands arrive sign-extended to SAT_W; the result is clamped to acc_w bits.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] acc,
                                       input logic signed [SAT_W-1:0] term,
                                       input int                      acc_w);
    sat_res_t           res;
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    s  = {acc[SAT_W-1], acc} + {term[SAT_W-1], term};
    hi = ({{SAT_W{1'b0}}, 1'b1} << (acc_w - 1)) - 1;
    lo = ~hi;
    if (s > hi) begin
      res.sum = hi[SAT_W-1:0];
      res.ovf = 1'b1;
    end else if (s < lo) begin
      res.sum = lo[SAT_W-1:0];
      res.ovf = 1'b1;
    end else begin
      res.sum = s[SAT_W-1:0];
      res.ovf = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sm_mac_accum_if.sv
// Product-in / result-out handshake bundle between multiplier, accumulator and writeback.
interface sm_mac_accum_if #(
  parameter int ACC_W = 12
);
  import sm_mac_accum_pkg::*;

  logic                    start;
  logic                    in_valid;
  logic                    in_ready;
  logic [PROD_W-1:0]       prod_mag;
  logic                    prod_sign;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] acc_out;
  logic                    sat_flag;
  logic                    busy;

  modport master (
    output start, in_valid, prod_mag, prod_sign, out_ready,
    input  in_ready, out_valid, acc_out, sat_flag, busy
  );

  modport slave (
    input  start, in_valid, prod_mag, prod_sign, out_ready,
    output in_ready, out_valid, acc_out, sat_flag, busy
  );

endinterface

// File: rtl/sm_mac_accum_sm_to_tc.sv
// Combinational sign-magnitude to two's-complement converter; negative zero maps to 0.
module sm_to_tc
  import sm_mac_accum_pkg::*;
#(
  parameter int OUT_W = 12
) (
  input  logic [PROD_W-1:0]       mag,
  input  logic                    sign,
  output logic signed [OUT_W-1:0] tc
);

  logic signed [OUT_W-1:0] mag_ext;

  assign mag_ext = OUT_W'(mag);
  assign tc      = sign ? -mag_ext : mag_ext;

endmodule

// File: rtl/sm_mac_accum.sv
// Saturating dot-product accumulator: NTERMS sign-magnitude products in, one
// signed (optionally ReLU-clamped) result out over a valid/ready handshake.
module sm_mac_accum
  import sm_mac_accum_pkg::*;
#(
  parameter int NTERMS  = 9,
  parameter int ACC_W   = 12,
  parameter int RELU_EN = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sm_mac_accum_if.slave  bus
);

  state_t                  state_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_out_reg;
  logic [7:0]              count_reg;
  logic                    sat_reg;

  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sum_sat;
  logic signed [ACC_W-1:0] result;
  logic                    ovf;
  logic                    last_term;
  logic                    unused_hi;
  sat_res_t                sat_res;

  sm_to_tc #(.OUT_W(ACC_W)) u_conv (
    .mag  (bus.prod_mag),
    .sign (bus.prod_sign),
    .tc   (term)
  );

  always_comb begin
    sat_res = sat_add(SAT_W'(acc_reg), SAT_W'(term), ACC_W);
  end

  assign sum_sat   = sat_res.sum[ACC_W-1:0];
  assign ovf       = sat_res.ovf;
  assign unused_hi = ^sat_res.sum[SAT_W-1:ACC_W];
  assign result    = (RELU_EN != 0 && sum_sat[ACC_W-1]) ? '0 : sum_sat;
  assign last_term = (count_reg == 8'(NTERMS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      count_reg   <= '0;
      acc_out_reg <= '0;
      sat_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
          end
        end
        ACCUM: begin
          // in_ready is high for the whole state, so in_valid alone is an accept
          if (bus.in_valid) begin
            acc_reg   <= sum_sat;
            count_reg <= count_reg + 8'd1;
            if (ovf) begin
              sat_reg <= 1'b1;
            end
            if (last_term) begin
              state_reg   <= DONE;
              acc_out_reg <= result;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            if (bus.start) begin
              state_reg <= ACCUM;
              acc_reg   <= '0;
              count_reg <= '0;
              sat_reg   <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == ACCUM);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.acc_out   = acc_out_reg;
  assign bus.sat_flag  = sat_reg;

endmodule

// File: tb/tb_sm_mac_accum.sv
// Drives three accumulator configurations in lockstep and scores each result
// against a saturating reference model queued when the final product is driven.
module tb_sm_mac_accum;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       prod_sign = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] prod_mag  = 4'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] val;
    logic        sat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  // inst 0: ACC_W=12 raw, inst 1: ACC_W=12 ReLU, inst 2: ACC_W=5 raw
  sm_mac_accum_if #(.ACC_W(12)) if0 ();
  sm_mac_accum_if #(.ACC_W(12)) if1 ();
  sm_mac_accum_if #(.ACC_W(5))  if2 ();

  assign if0.start = start;     assign if1.start = start;     assign if2.start = start;
  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid; assign if2.in_valid = in_valid;
  assign if0.prod_mag = prod_mag; assign if1.prod_mag = prod_mag; assign if2.prod_mag = prod_mag;
  assign if0.prod_sign = prod_sign; assign if1.prod_sign = prod_sign; assign if2.prod_sign = prod_sign;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  sm_mac_accum #(.NTERMS(9), .ACC_W(12), .RELU_EN(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sm_mac_accum #(.NTERMS(9), .ACC_W(12), .RELU_EN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  sm_mac_accum #(.NTERMS(9), .ACC_W(5),  .RELU_EN(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [2:0]  rdy, ovs, bsy, sats;
  logic [11:0] ao0, ao1, ao2;

  assign rdy  = {if0.in_ready,  if1.in_ready,  if2.in_ready};
  assign ovs  = {if0.out_valid, if1.out_valid, if2.out_valid};
  assign bsy  = {if0.busy,      if1.busy,      if2.busy};
  assign sats = {if0.sat_flag,  if1.sat_flag,  if2.sat_flag};
  assign ao0  = if0.acc_out;
  assign ao1  = if1.acc_out;
  assign ao2  = {7'd0, if2.acc_out};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int aw, input bit relu, input int mag[9], input bit sg[9]);
    exp_t e;
    int   acc;
    int   hi;
    int   lo;
    acc   = 0;
    hi    = (1 << (aw - 1)) - 1;
    lo    = -(1 << (aw - 1));
    e.sat = 1'b0;
    for (int i = 0; i < 9; i++) begin
      acc = acc + (sg[i] ? -mag[i] : mag[i]);
      if (acc > hi) begin
        acc   = hi;
        e.sat = 1'b1;
      end else if (acc < lo) begin
        acc   = lo;
        e.sat = 1'b1;
      end
    end
    if (relu && acc < 0) acc = 0;
    acc   = acc & ((1 << aw) - 1);
    e.val = acc[11:0];
    return e;
  endfunction

  task automatic score(input int idx, input logic [11:0] obs, input logic sat);
    exp_t e;
    int   n;
    n = (idx == 0) ? q0.size() : (idx == 1) ? q1.size() : q2.size();
    chk($sformatf("sb_pending%0d", idx), 32'(n > 0), 32'd1);
    if (n > 0) begin
      if (idx == 0)      e = q0.pop_front();
      else if (idx == 1) e = q1.pop_front();
      else               e = q2.pop_front();
      $display("result inst%0d: acc_out=%0h sat=%0b (expect %0h/%0b)", idx, obs, sat, e.val, e.sat);
      chk($sformatf("acc_out%0d", idx), 32'(obs), 32'(e.val));
      chk($sformatf("sat_flag%0d", idx), 32'(sat), 32'(e.sat));
    end
  endtask

  logic [2:0] ov_prev = 3'b000;
  always @(negedge clk) begin
    if (ovs[2] && !ov_prev[2]) score(0, ao0, if0.sat_flag);
    if (ovs[1] && !ov_prev[1]) score(1, ao1, if1.sat_flag);
    if (ovs[0] && !ov_prev[0]) score(2, ao2, if2.sat_flag);
    ov_prev = ovs;
  end

  task automatic wait_ready;
    int n;
    n = 0;
    while (rdy !== 3'b111 && n < 20) begin
      step;
      n++;
    end
    chk("in_ready_wait", 32'(rdy), 32'd7);
  endtask

  // Runs one dot product; the expected results are queued as the last product is driven.
  task automatic run(input int mag[9], input bit sg[9], input int gap, input bit poke, input bit do_start);
    if (do_start) begin
      start = 1'b1;
      step;
      start = 1'b0;
    end
    for (int i = 0; i < 9; i++) begin
      in_valid  = 1'b1;
      prod_mag  = 4'(mag[i]);
      prod_sign = sg[i];
      wait_ready;
      if (i == 8) begin
        q0.push_back(model(12, 1'b0, mag, sg));
        q1.push_back(model(12, 1'b1, mag, sg));
        q2.push_back(model(5,  1'b0, mag, sg));
        chk("ov_before_last", 32'(ovs), 32'd0);
      end
      step;
      if (i == 8) begin
        in_valid = 1'b0;
        chk("latency_ov", 32'(ovs), 32'd7);
      end else if (gap > 0) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          start = poke && (g == 0) && (i == 3);
          step;
        end
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int m[9];
    bit s[9];

    step;
    step;
    chk("rst_in_ready", 32'(rdy), 32'd0);
    chk("rst_out_valid", 32'(ovs), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_sat", 32'(sats), 32'd0);
    chk("rst_acc_out", 32'({ao0, ao1, ao2}), 32'd0);
    rst_n = 1'b1;
    step;

    // reset mid-run after four +9 products
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      prod_mag = 4'd9;
      prod_sign = 1'b0;
      step;
    end
    in_valid = 1'b0;
    chk("midrun_busy", 32'(bsy), 32'd7);
    chk("midrun_sat", 32'(sats), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bsy), 32'd0);
    chk("async_rst_ready", 32'(rdy), 32'd0);
    chk("async_rst_sat", 32'(sats), 32'd0);
    chk("async_rst_ov", 32'(ovs), 32'd0);
    step;
    rst_n = 1'b1;
    step;

    m = '{1, 1, 1, 1, 1, 1, 1, 1, 1}; s = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run(m, s, 0, 1'b0, 1'b1);
    step;

    m = '{9, 4, 6, 1, 0, 0, 2, 9, 3}; s = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    run(m, s, 0, 1'b0, 1'b1);
    step;

    m = '{3, 3, 3, 3, 3, 3, 3, 3, 3}; s = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run(m, s, 0, 1'b0, 1'b1);
    step;

    m = '{9, 9, 9, 9, 9, 9, 9, 9, 9}; s = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run(m, s, 0, 1'b0, 1'b1);
    step;

    s = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run(m, s, 0, 1'b0, 1'b1);
    step;

    // downstream stall: result must hold, inputs and start must be ignored
    out_ready = 1'b0;
    s = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run(m, s, 0, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      prod_mag = 4'd9;
      start    = (c == 2);
      chk("stall_ov", 32'(ovs), 32'd7);
      chk("stall_ready", 32'(rdy), 32'd0);
      chk("stall_acc0", 32'(ao0), 32'd81);
      chk("stall_acc2", 32'(ao2), 32'd15);
      chk("stall_sat", 32'(sats), 32'd1);
      step;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    step;
    start = 1'b0;
    chk("b2b_ov", 32'(ovs), 32'd0);
    chk("b2b_ready", 32'(rdy), 32'd7);
    chk("b2b_sat_clr", 32'(sats), 32'd0);
    m = '{2, 2, 2, 2, 2, 2, 2, 2, 2}; s = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run(m, s, 0, 1'b0, 1'b0);
    step;

    // bubbles, in_valid in IDLE (also alongside start), start pulsed in ACCUM
    in_valid  = 1'b1;
    prod_mag  = 4'd5;
    prod_sign = 1'b0;
    step;
    step;
    prod_mag = 4'd7;
    m = '{1, 2, 3, 4, 5, 6, 7, 8, 1}; s = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    run(m, s, 2, 1'b1, 1'b1);
    step;
    step;

    chk("sb_drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
